// File: rtl/ram_port_arbiter.sv
// Two-master req/gnt/rvalid arbiter in front of one single-ported RAM slave.
// Optional response timeout is compiled in with `define ARB_TIMEOUT_EN.
module ram_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  m_req,
  input  logic [1:0]  m_we,
  input  logic [7:0]  m_be,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic [1:0]  m_gnt,
  output logic [1:0]  m_rvalid,
  output logic [63:0] m_rdata,
  output logic [1:0]  m_err,
  output logic        s_req,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic        s_err,
  input  logic [31:0] s_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_served_q, last_served_d;

  logic        winner;
  logic        timeout_hit;
  logic        fwd_en;
  logic        fwd_idx;
  logic [1:0]  gnt_c;
  logic [1:0]  rvalid_c;
  logic [1:0]  err_c;
  logic [63:0] rdata_c;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;

  assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
  assign timeout_hit = (state_q == WAIT_RSP) && !s_rvalid &&
                       (cnt_inc == 17'(TIMEOUT_CYCLES));

  // Counter is zero on the first WAIT_RSP cycle and counts up while waiting.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT_RSP) cnt_d = cnt_inc[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // No counter in this build; the parameter is still referenced so the
  // module interface is identical in both builds.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_comb begin
    winner = 1'b0;
    if (m_req == 2'b10)      winner = 1'b1;
    else if (m_req == 2'b11) winner = FIXED_PRIORITY ? 1'b0 : ~last_served_q;
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    fwd_en        = 1'b0;
    fwd_idx       = owner_q;
    gnt_c         = 2'b00;
    rvalid_c      = 2'b00;
    err_c         = 2'b00;
    rdata_c       = '0;
    case (state_q)
      IDLE: begin
        if (|m_req) begin
          fwd_en         = 1'b1;
          fwd_idx        = winner;
          owner_d        = winner;
          gnt_c[winner]  = s_gnt;
          state_d        = s_gnt ? WAIT_RSP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (m_req[owner_q]) begin
          fwd_en         = 1'b1;
          gnt_c[owner_q] = s_gnt;
          if (s_gnt) state_d = WAIT_RSP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        if (s_rvalid) begin
          rvalid_c[owner_q] = 1'b1;
          err_c[owner_q]    = s_err;
          if (owner_q) rdata_c[63:32] = s_rdata;
          else         rdata_c[31:0]  = s_rdata;
          last_served_d     = owner_q;
          state_d           = IDLE;
        end else if (timeout_hit) begin
          rvalid_c[owner_q] = 1'b1;
          err_c[owner_q]    = 1'b1;
          last_served_d     = owner_q;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
    end
  end

  // Reset forces every output low immediately, independent of the masters.
  assign m_gnt    = {2{rst_n}} & gnt_c;
  assign m_rvalid = {2{rst_n}} & rvalid_c;
  assign m_err    = {2{rst_n}} & err_c;
  assign m_rdata  = {64{rst_n}} & rdata_c;

  assign s_req   = rst_n & fwd_en;
  assign s_we    = s_req & (fwd_idx ? m_we[1] : m_we[0]);
  assign s_be    = {4{s_req}} & (fwd_idx ? m_be[7:4] : m_be[3:0]);
  assign s_addr  = {32{s_req}} & (fwd_idx ? m_addr[63:32] : m_addr[31:0]);
  assign s_wdata = {32{s_req}} & (fwd_idx ? m_wdata[63:32] : m_wdata[31:0]);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed table-driven bench for ram_port_arbiter, plus reset and timeout sequences.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam logic [31:0] A0  = 32'h0000_1000;
  localparam logic [31:0] A1  = 32'h0001_0040;
  localparam logic [31:0] WD0 = 32'h1234_5678;
  localparam logic [31:0] WD1 = 32'hCAFE_0001;
  localparam logic [3:0]  BE0 = 4'hF;
  localparam logic [3:0]  BE1 = 4'h3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req;
  logic [1:0]  m_we;
  logic [7:0]  m_be;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_gnt;
  logic [1:0]  m_rvalid;
  logic [63:0] m_rdata;
  logic [1:0]  m_err;
  logic        s_req;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_gnt;
  logic        s_rvalid;
  logic        s_err;
  logic [31:0] s_rdata;

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(.TIMEOUT_CYCLES(4), .FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  req;
    logic        sg;
    logic        srv;
    logic        serr;
    logic [31:0] srd;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [1:0]  e_err;
    logic [1:0]  e_sel;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(string nm, logic [1:0] req, logic sg, logic srv, logic serr,
                              logic [31:0] srd, logic [1:0] eg, logic [1:0] erv,
                              logic [1:0] eerr, logic [1:0] esel);
    vec_t v;
    v.name = nm; v.req = req; v.sg = sg; v.srv = srv; v.serr = serr; v.srd = srd;
    v.e_gnt = eg; v.e_rv = erv; v.e_err = eerr; v.e_sel = esel;
    return v;
  endfunction

  function automatic logic [63:0] rd_exp(logic [1:0] rv, logic [31:0] srd);
    if (rv == 2'b01) return {32'h0, srd};
    if (rv == 2'b10) return {srd, 32'h0};
    return 64'h0;
  endfunction

  task automatic drive(logic [1:0] req, logic sg, logic srv, logic serr, logic [31:0] srd);
    m_req = req; s_gnt = sg; s_rvalid = srv; s_err = serr; s_rdata = srd;
  endtask

  // esel: which master's request fields should appear on s_* (00 = none).
  task automatic check(string nm, logic [1:0] eg, logic [1:0] erv, logic [1:0] eerr,
                       logic [1:0] esel, logic [63:0] erd);
    logic        e_sreq, e_swe;
    logic [3:0]  e_sbe;
    logic [31:0] e_saddr, e_swd;
    e_sreq  = (esel != 2'b00);
    e_swe   = (esel == 2'b01);
    e_sbe   = (esel == 2'b01) ? BE0 : (esel == 2'b10) ? BE1 : 4'h0;
    e_saddr = (esel == 2'b01) ? A0  : (esel == 2'b10) ? A1  : 32'h0;
    e_swd   = (esel == 2'b01) ? WD0 : (esel == 2'b10) ? WD1 : 32'h0;
    total++;
    if (m_gnt !== eg || m_rvalid !== erv || m_err !== eerr || m_rdata !== erd ||
        s_req !== e_sreq || s_we !== e_swe || s_be !== e_sbe ||
        s_addr !== e_saddr || s_wdata !== e_swd) begin
      bad++;
      $display("FAIL %s: got gnt=%b rv=%b err=%b rdata=%h sreq=%b swe=%b sbe=%h saddr=%h swd=%h | want gnt=%b rv=%b err=%b rdata=%h sreq=%b swe=%b sbe=%h saddr=%h swd=%h",
               nm, m_gnt, m_rvalid, m_err, m_rdata, s_req, s_we, s_be, s_addr, s_wdata,
               eg, erv, eerr, erd, e_sreq, e_swe, e_sbe, e_saddr, e_swd);
    end
  endtask

  initial begin
    vecs[0]  = mk("idle",       2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 2'b00);
    vecs[1]  = mk("tie_m0",     2'b11, 1, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 2'b01);
    vecs[2]  = mk("rsp_m0",     2'b11, 0, 1, 0, 32'h1111_1111, 2'b00, 2'b01, 2'b00, 2'b00);
    vecs[3]  = mk("tie_m1",     2'b11, 1, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 2'b10);
    vecs[4]  = mk("rsp_m1",     2'b11, 0, 1, 0, 32'h2222_2222, 2'b00, 2'b10, 2'b00, 2'b00);
    vecs[5]  = mk("tie_m0b",    2'b11, 1, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 2'b01);
    vecs[6]  = mk("err_m0",     2'b11, 0, 1, 1, 32'h3333_3333, 2'b00, 2'b01, 2'b01, 2'b00);
    vecs[7]  = mk("stray_idle", 2'b00, 0, 1, 1, 32'hFFFF_FFFF, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[8]  = mk("wgnt_0",     2'b01, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 2'b01);
    vecs[9]  = mk("wgnt_1",     2'b11, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 2'b01);
    vecs[10] = mk("wgnt_2",     2'b11, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 2'b01);
    vecs[11] = mk("wgnt_late",  2'b11, 1, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 2'b01);
    vecs[12] = mk("wrsp_block", 2'b11, 1, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 2'b00);
    vecs[13] = mk("wrsp_m0",    2'b11, 0, 1, 0, 32'hDEAD_BEEF, 2'b00, 2'b01, 2'b00, 2'b00);
    vecs[14] = mk("read_m1",    2'b11, 1, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 2'b10);
    vecs[15] = mk("read_rsp",   2'b10, 0, 1, 0, 32'hDEAD_BEEF, 2'b00, 2'b10, 2'b00, 2'b00);
    vecs[16] = mk("drop_a",     2'b10, 0, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 2'b10);
    vecs[17] = mk("drop_b",     2'b01, 1, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 2'b00);
    vecs[18] = mk("after_drop", 2'b11, 1, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 2'b01);
    vecs[19] = mk("rsp_m0d",    2'b00, 0, 1, 0, 32'h0000_0005, 2'b00, 2'b01, 2'b00, 2'b00);
    vecs[20] = mk("pre_rst_m1", 2'b11, 1, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 2'b10);

    m_we    = 2'b01;
    m_be    = {BE1, BE0};
    m_addr  = {A1, A0};
    m_wdata = {WD1, WD0};

    rst_n = 1'b0;
    drive(2'b11, 1, 1, 1, 32'hFFFF_FFFF);
    #12;
    check("rst_hold", 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 0, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].sg, vecs[i].srv, vecs[i].serr, vecs[i].srd);
      #1;
      check(vecs[i].name, vecs[i].e_gnt, vecs[i].e_rv, vecs[i].e_err, vecs[i].e_sel,
            rd_exp(vecs[i].e_rv, vecs[i].srd));
    end

    // Reset while m1 waits for its response; last_served must return to 1.
    @(negedge clk);
    rst_n = 1'b0;
    drive(2'b11, 1, 1, 0, 32'hFFFF_FFFF);
    #1;
    check("rst_mid", 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 1, 0, 0, 32'h0);
    #1;
    check("rst_tie_m0", 2'b01, 2'b00, 2'b00, 2'b01, 64'h0);

`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive(2'b00, 0, 0, 0, 32'hABCD_0000);
      #1;
      check($sformatf("to_wait%0d", c), 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
    end
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 32'hABCD_0000);
    #1;
    check("to_fire", 2'b00, 2'b01, 2'b01, 2'b00, 64'h0);
    @(negedge clk);
    drive(2'b00, 0, 1, 0, 32'h0000_0077);
    #1;
    check("to_stray", 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
    @(negedge clk);
    drive(2'b11, 1, 0, 0, 32'h0);
    #1;
    check("to_rr_m1", 2'b10, 2'b00, 2'b00, 2'b10, 64'h0);
`else
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      drive(2'b00, 0, 0, 0, 32'hABCD_0000);
      #1;
      check($sformatf("no_to%0d", c), 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);
    end
    @(negedge clk);
    drive(2'b00, 0, 1, 0, 32'h0000_0077);
    #1;
    check("late_rsp", 2'b00, 2'b01, 2'b00, 2'b00, {32'h0, 32'h0000_0077});
`endif

    @(negedge clk);
    drive(2'b00, 0, 0, 0, 32'h0);
    #1;
    check("final_idle", 2'b00, 2'b00, 2'b00, 2'b00, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one single-ported RAM slave between two Ibex-style instruction/data masters. Master 0 is the core data bus; master 1 is the loader/debug bus. Uses the req/gnt/rvalid protocol and allows one outstanding transaction at a time. Ties are resolved round-robin, and the granted master is locked until its response completes.

Parameters:
TIMEOUT_CYCLES, 255, response-wait limit in cycles; used only with ARB_TIMEOUT_EN; legal range 1..65535.
FIXED_PRIORITY, 0, 1 makes master 0 always win ties (round-robin disabled).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
m_req  input  2  per-master request; bit i = master i
m_we  input  2  per-master write enable
m_be  input  8  byte enables; [4i+3:4i] = master i
m_addr  input  64  addresses; [32i+31:32i] = master i
m_wdata  input  64  write data, packed as m_addr
m_gnt  output  2  per-master grant
m_rvalid  output  2  per-master response valid
m_rdata  output  64  read data, packed; zero for non-owner
m_err  output  2  per-master error
s_req, s_we  output  1 each  slave request, write enable
s_be  output  4  slave byte enables
s_addr, s_wdata  output  32 each  slave address, write data
s_gnt, s_rvalid, s_err  input  1 each  slave grant, response valid, error
s_rdata  input  32  slave read data

Behaviour:
- Registers: state {IDLE, WAIT_GNT, WAIT_RSP}, owner (1 bit), last_served (1 bit).
- Reset values: state=IDLE, owner=0, last_served=1, so master 0 wins the first tie.
- All outputs are combinational from registers and inputs. With no activity they are all 0.
- IDLE, winner selection:
  - Only one m_req set: that master wins.
  - Both set: winner = ~last_served, or 0 if FIXED_PRIORITY=1.
- IDLE, forwarding: the winner's req/we/be/addr/wdata drive s_*. m_gnt[winner]=s_gnt. owner<=winner.
- IDLE, transition: s_gnt=1 goes to WAIT_RSP; s_gnt=0 goes to WAIT_GNT.
- WAIT_GNT:
  - Forward only owner's signals; the other master's gnt is held 0 even if it requests.
  - s_gnt goes to WAIT_RSP.
  - If the owner drops req before gnt (protocol violation), return to IDLE with no state update.
- WAIT_RSP:
  - s_req=0; all s_* outputs are 0.
  - Owner gets m_rvalid/m_rdata/m_err from the slave.
  - On s_rvalid: set last_served<=owner and go to IDLE.
- No pipelining: a new grant can be issued at the earliest in the cycle after rvalid. Throughput is at most one transaction per 2 cycles with a zero-wait slave.
- s_rvalid seen in IDLE or WAIT_GNT is a stray response. It is dropped and never forwarded.
- The non-owner sees gnt=0, rvalid=0, rdata=0, err=0 at all times.
- Reset mid-operation: all registers return to their reset values immediately, and outputs go to 0 asynchronously. The in-flight response is lost.
- Masters must hold req/we/be/addr/wdata stable until gnt. The arbiter does not check this except for the req drop in WAIT_GNT.

Optional Feature:
Macro: ARB_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entering WAIT_RSP and increments each cycle in WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES with no s_rvalid, the owner gets m_rvalid=1, m_err=1, m_rdata=0 for one cycle.
  - The arbiter then goes to IDLE and updates last_served.
  - A late s_rvalid is dropped as stray.
- Not defined: no counter exists, and WAIT_RSP waits indefinitely.

Test Plan:
- Tie, zero-wait slave: both masters request continuously after reset → first gnt to m0, then m1, then m0. Grant pulses alternate on cycles 0, 2, 4.
- Slave gnt delayed 3 cycles, m1 asserts req at cycle 1 → m0 stays owner. m_gnt[1]=0 until m0's rvalid. s_addr holds m0's address throughout.
- Read: m1 reads addr 0x0001_0040, slave returns 0xDEADBEEF with s_err=0 → m_rdata[63:32]=0xDEADBEEF and m_rvalid=2'b10. m_rdata[31:0]=0.
- Stray response: s_rvalid pulsed in IDLE → m_rvalid=2'b00 and state stays IDLE.
- Reset mid-operation: rst_n pulled low in WAIT_RSP, then released → all outputs 0 during reset. After release, a tie grants m0 first.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4: slave never sends rvalid → m_rvalid[owner]=1 and m_err=1 exactly 4 cycles after gnt. A later s_rvalid is ignored.
